tg_burst_sequencer: RTL and testbench

Sequences the 14-bit AXI-stream test-pattern generator into programmable bursts. It gates the generator's `extenable` so that each burst carries exactly N accepted beats, inserts idle gaps between bursts, and repeats a programmed number of bursts or runs continuously. It also pulses the generator's `resetn` at the start of every run so the pattern restarts at 0. It sits between the control/register logic and the generator instance, and observes the generator's AXI-stream handshake.

---
 rtl/tg_seq_pkg.sv | 22 ++
 rtl/tg_seq_sat_counter.sv | 20 ++
 rtl/tg_burst_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tg_burst_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tg_seq_pkg.sv
// Shared types and default widths for the test-pattern burst sequencer.
package tg_seq_pkg;

  localparam int TG_SEQ_LEN_W = 16;
  localparam int TG_SEQ_CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BURST,
    GAP,
    DONE
  } tg_seq_state_t;

  // Configuration snapshot taken at start; fields are carried at the default width.
  typedef struct packed {
    logic [TG_SEQ_LEN_W-1:0] burst_len;
    logic [TG_SEQ_LEN_W-1:0] gap;
    logic [TG_SEQ_LEN_W-1:0] num_bursts;
  } tg_seq_cfg_t;

endpackage

// File: rtl/tg_seq_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module tg_seq_sat_counter #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge aclk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/tg_burst_sequencer.sv
// Gates the test-pattern generator into bursts of exactly N accepted beats with idle gaps.
// Optional TG_SEQ_STATS_EN adds stall_cycles and max_burst_cycles counters.
//
// state | meaning
// IDLE  | waiting for start, generator enabled-off and out of reset
// ARM   | one cycle with generator held in reset so the pattern restarts at 0
// BURST | extenable high, counting accepted beats
// GAP   | extenable low for cfg_gap cycles between bursts
// DONE  | one-cycle done pulse at the end of a finite run
module tg_burst_sequencer
  import tg_seq_pkg::*;
#(
  parameter int LEN_W = TG_SEQ_LEN_W,
  parameter int CNT_W = TG_SEQ_CNT_W
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_burst_len,
  input  logic [LEN_W-1:0] cfg_gap,
  input  logic [LEN_W-1:0] cfg_num_bursts,
  output logic             tg_resetn,
  output logic             tg_enable,
  input  logic             tg_tvalid,
  input  logic             tg_tready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] burst_idx,
  output logic [CNT_W-1:0] beats_total
`ifdef TG_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] max_burst_cycles
`endif
);

  tg_seq_state_t    state_q;
  tg_seq_state_t    state_nxt;
  tg_seq_cfg_t      cfg_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] gap_cnt;
  logic [LEN_W-1:0] len_m1;
  logic             beat;
  logic             last_beat;
  logic             last_burst;
  logic             start_ok;

  assign beat       = tg_tvalid & tg_tready & tg_enable;
  assign len_m1     = LEN_W'(cfg_q.burst_len) - LEN_W'(1);
  assign last_beat  = beat && (beat_cnt == len_m1);
  assign last_burst = (cfg_q.num_bursts != '0) &&
                      (burst_idx == LEN_W'(cfg_q.num_bursts) - LEN_W'(1));
  assign start_ok   = start && !abort && (state_q == IDLE);

  always_comb begin
    state_nxt = state_q;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start_ok) state_nxt = ARM;
        ARM:   state_nxt = BURST;
        BURST: begin
          if (last_beat) begin
            if (last_burst)            state_nxt = DONE;
            else if (cfg_q.gap != '0)  state_nxt = GAP;
          end
        end
        GAP:   if (gap_cnt == '0) state_nxt = BURST;
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q   <= IDLE;
      tg_resetn <= 1'b1;
      tg_enable <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_q     <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      burst_idx <= '0;
    end else begin
      state_q   <= state_nxt;
      tg_resetn <= (state_nxt != ARM);
      tg_enable <= (state_nxt == BURST);
      busy      <= (state_nxt inside {ARM, BURST, GAP});
      done      <= (state_nxt == DONE);

      if (start_ok) begin
        cfg_q.burst_len  <= (cfg_burst_len == '0) ? TG_SEQ_LEN_W'(1)
                                                  : TG_SEQ_LEN_W'(cfg_burst_len);
        cfg_q.gap        <= TG_SEQ_LEN_W'(cfg_gap);
        cfg_q.num_bursts <= TG_SEQ_LEN_W'(cfg_num_bursts);
        beat_cnt         <= '0;
        burst_idx        <= '0;
      end

      // Abort freezes burst_idx; the gap timer reloads as a down-counter at each burst end.
      if (!abort && (state_q == BURST) && beat) begin
        if (last_beat) begin
          beat_cnt <= '0;
          gap_cnt  <= LEN_W'(cfg_q.gap) - LEN_W'(1);
          if (!last_burst) burst_idx <= burst_idx + LEN_W'(1);
        end else begin
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
      end

      if (!abort && (state_q == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - LEN_W'(1);
      end
    end
  end

  tg_seq_sat_counter #(.W(CNT_W)) u_beats (
    .aclk  (aclk),
    .reset (reset),
    .clr   (start_ok),
    .en    (beat),
    .q     (beats_total)
  );

`ifdef TG_SEQ_STATS_EN
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] burst_dwell;

  tg_seq_sat_counter #(.W(CNT_W)) u_stall (
    .aclk  (aclk),
    .reset (reset),
    .clr   (start_ok),
    .en    ((state_q == BURST) && tg_tvalid && !tg_tready),
    .q     (stall_cycles)
  );

  // Cycles spent in the current burst so far, restarted at every burst boundary.
  tg_seq_sat_counter #(.W(CNT_W)) u_dwell (
    .aclk  (aclk),
    .reset (reset),
    .clr   ((state_q != BURST) || last_beat),
    .en    (state_q == BURST),
    .q     (dwell_cnt)
  );

  assign burst_dwell = (dwell_cnt == '1) ? dwell_cnt : dwell_cnt + CNT_W'(1);

  always_ff @(posedge aclk) begin
    if (reset || start_ok) begin
      max_burst_cycles <= '0;
    end else if ((state_q == BURST) && last_beat && (burst_dwell > max_burst_cycles)) begin
      max_burst_cycles <= burst_dwell;
    end
  end
`endif

endmodule

// File: tb/tb_tg_burst_sequencer.sv
// Directed vector bench for tg_burst_sequencer; build with TG_SEQ_STATS_EN to cover the stats ports.
module tb_tg_burst_sequencer;

  logic        aclk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] cfg_burst_len, cfg_gap, cfg_num_bursts;
  logic        tg_resetn, tg_enable, tg_tvalid, tg_tready;
  logic        busy, done;
  logic [15:0] burst_idx;
  logic [31:0] beats_total;
`ifdef TG_SEQ_STATS_EN
  logic [31:0] stall_cycles, max_burst_cycles;
`endif

  always #5 aclk = ~aclk;

  tg_burst_sequencer dut (
    .aclk           (aclk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_gap        (cfg_gap),
    .cfg_num_bursts (cfg_num_bursts),
    .tg_resetn      (tg_resetn),
    .tg_enable      (tg_enable),
    .tg_tvalid      (tg_tvalid),
    .tg_tready      (tg_tready),
    .busy           (busy),
    .done           (done),
    .burst_idx      (burst_idx),
    .beats_total    (beats_total)
`ifdef TG_SEQ_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .max_burst_cycles (max_burst_cycles)
`endif
  );

  typedef struct {
    logic        rst, st, ab, rdy;
    logic [15:0] len, gap, num;
    logic        e_en, e_rstn, e_busy, e_done;
    logic [15:0] e_idx;
    logic [31:0] e_tot;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] cur_len, cur_gap, cur_num;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_starts = 0;
  int          rstn_low = 0;
  int          done_cnt = 0;
  int          en_cnt = 0;
  bit          mon_on = 0;

  always @(negedge aclk) begin
    if (mon_on) begin
      if (!tg_resetn) rstn_low++;
      if (done) done_cnt++;
      if (tg_enable) en_cnt++;
    end
  end

  function automatic void set_cfg(input int l, input int g, input int n);
    cur_len = 16'(l);
    cur_gap = 16'(g);
    cur_num = 16'(n);
  endfunction

  function automatic void add(input logic rst, input logic st, input logic ab, input logic rdy,
                              input logic en, input logic rstn, input logic bsy, input logic dn,
                              input int idx, input int tot);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.rdy = rdy;
    v.len = cur_len; v.gap = cur_gap; v.num = cur_num;
    v.e_en = en; v.e_rstn = rstn; v.e_busy = bsy; v.e_done = dn;
    v.e_idx = 16'(idx); v.e_tot = 32'(tot);
    if (!rstn) n_starts++;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input int i, input vec_t v);
    chk("tg_enable", i, 32'(tg_enable), 32'(v.e_en));
    chk("tg_resetn", i, 32'(tg_resetn), 32'(v.e_rstn));
    chk("busy", i, 32'(busy), 32'(v.e_busy));
    chk("done", i, 32'(done), 32'(v.e_done));
    chk("burst_idx", i, 32'(burst_idx), 32'(v.e_idx));
    chk("beats_total", i, beats_total, v.e_tot);
  endtask

  initial begin
    int tot;
    int rdy_pat[13];
    bit found;

    // --- len=4 gap=2 num=3, config changed after start must be ignored
    set_cfg(4, 2, 3);
    add(0,1,0,1, 0,0,1,0, 0,0);
    set_cfg(9, 9, 9);
    add(0,0,0,1, 1,1,1,0, 0,0);
    tot = 0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 3; k++) begin
        tot++;
        add(0,0,0,1, 1,1,1,0, b,tot);
      end
      tot++;
      if (b < 2) begin
        add(0,0,0,1, 0,1,1,0, b+1,tot);
        add(0,0,0,1, 0,1,1,0, b+1,tot);
        add(0,0,0,1, 1,1,1,0, b+1,tot);
      end else begin
        add(0,0,0,1, 0,1,0,1, 2,12);
        add(0,0,0,1, 0,1,0,0, 2,12);
      end
    end

    // --- len=0 treated as 1, gap=0, num=2
    set_cfg(0, 0, 2);
    add(0,1,0,1, 0,0,1,0, 0,0);
    add(0,0,0,1, 1,1,1,0, 0,0);
    add(0,0,0,1, 1,1,1,0, 1,1);
    add(0,0,0,1, 0,1,0,1, 1,2);
    add(0,0,0,1, 0,1,0,0, 1,2);

    // --- start while busy ignored, start+abort resolves as abort
    set_cfg(4, 2, 3);
    add(0,1,0,1, 0,0,1,0, 0,0);
    add(0,1,0,1, 1,1,1,0, 0,0);
    add(0,1,0,1, 1,1,1,0, 0,1);
    add(0,1,1,0, 0,1,0,0, 0,1);
    add(0,1,1,1, 0,1,0,0, 0,1);
    add(0,0,0,1, 0,1,0,0, 0,1);

    // --- reset mid-GAP, then a clean run from zero
    add(0,1,0,1, 0,0,1,0, 0,0);
    add(0,0,0,1, 1,1,1,0, 0,0);
    add(0,0,0,1, 1,1,1,0, 0,1);
    add(0,0,0,1, 1,1,1,0, 0,2);
    add(0,0,0,1, 1,1,1,0, 0,3);
    add(0,0,0,1, 0,1,1,0, 1,4);
    add(1,0,0,1, 0,1,0,0, 0,0);
    add(0,1,0,1, 0,0,1,0, 0,0);
    add(0,0,0,1, 1,1,1,0, 0,0);
    add(0,0,0,1, 1,1,1,0, 0,1);
    add(0,0,1,0, 0,1,0,0, 0,1);

    // --- len=5 gap=1 num=1 with ready pattern 1,0,0 repeating
    set_cfg(5, 1, 1);
    add(0,1,0,1, 0,0,1,0, 0,0);
    add(0,0,0,1, 1,1,1,0, 0,0);
    rdy_pat = '{1,0,0,1,0,0,1,0,0,1,0,0,1};
    tot = 0;
    for (int c = 0; c < 13; c++) begin
      tot += rdy_pat[c];
      if (c < 12) add(0,0,0,1'(rdy_pat[c]), 1,1,1,0, 0,tot);
      else        add(0,0,0,1, 0,1,0,1, 0,5);
    end
    add(0,0,0,1, 0,1,0,0, 0,5);

    // --- reset
    reset = 1; start = 0; abort = 0; tg_tvalid = 1; tg_tready = 1;
    cfg_burst_len = 0; cfg_gap = 0; cfg_num_bursts = 0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset tg_enable", -1, 32'(tg_enable), 0);
    chk("reset tg_resetn", -1, 32'(tg_resetn), 1);
    chk("reset busy", -1, 32'(busy), 0);
    chk("reset done", -1, 32'(done), 0);
    chk("reset burst_idx", -1, 32'(burst_idx), 0);
    chk("reset beats_total", -1, beats_total, 0);
    reset = 0;
    mon_on = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab; tg_tready = vecs[i].rdy;
      cfg_burst_len = vecs[i].len; cfg_gap = vecs[i].gap; cfg_num_bursts = vecs[i].num;
      @(posedge aclk);
      #1;
      chk_all(i, vecs[i]);
    end
    reset = 0; start = 0; abort = 0; tg_tready = 1;

`ifdef TG_SEQ_STATS_EN
    chk("stall_cycles", -2, stall_cycles, 8);
    chk("max_burst_cycles", -2, max_burst_cycles, 13);
`endif

    // --- continuous len=8 gap=3: 10 bursts then abort
    cfg_burst_len = 8; cfg_gap = 3; cfg_num_bursts = 0;
    start = 1;
    @(posedge aclk);
    #1;
    start = 0;
    n_starts++;
    done_cnt = 0;
    en_cnt = 0;
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge aclk);
      #1;
      if (burst_idx == 16'd10) found = 1;
    end
    chk("cont reached 10 bursts", -3, 32'(found), 1);
    chk("cont enable cycles", -3, 32'(en_cnt), 80);
    abort = 1;
    @(posedge aclk);
    #1;
    abort = 0;
    chk("abort busy", -3, 32'(busy), 0);
    chk("abort tg_enable", -3, 32'(tg_enable), 0);
    repeat (4) @(posedge aclk);
    #1;
    chk("abort burst_idx held", -3, 32'(burst_idx), 10);
    chk("abort beats_total held", -3, beats_total, 80);
    chk("cont no done pulse", -3, 32'(done_cnt), 0);
    chk("resetn low cycles", -3, 32'(rstn_low), 32'(n_starts));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
